// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: operands and opcode in, registered result and status out.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, ALUControl,
    input  Result, Zero, Overflow, busy, done
  );

  modport slave (
    input  start, A, B, ALUControl,
    output Result, Zero, Overflow, busy, done
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops, iterative MUL/DIVU/REMU (WIDTH steps each).
// Define MULTICYCLE_ALU_MULDIV_EN to build the iterative ops; otherwise their opcodes behave as undefined.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic             multi_s;
  logic             last_s;
  logic [WIDTH-1:0] fin_s;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             ovf_r;
  logic             busy_s;
  logic             done_s;

  assign sum_s   = bus.A + bus.B;
  assign diff_s  = bus.A - bus.B;
  assign shamt_s = bus.B[SHW-1:0];

  // Single-cycle datapath evaluated on the live inputs in the accepting cycle
  always_comb begin
    alu_res_s = '0;
    alu_ovf_s = 1'b0;
    case (bus.ALUControl)
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  alu_res_s = bus.A & bus.B;
      OP_OR:   alu_res_s = bus.A | bus.B;
      OP_XOR:  alu_res_s = bus.A ^ bus.B;
      OP_NOR:  alu_res_s = ~(bus.A | bus.B);
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_SLL:  alu_res_s = bus.A << shamt_s;
      OP_SRL:  alu_res_s = bus.A >> shamt_s;
      OP_SRA:  alu_res_s = $signed(bus.A) >>> shamt_s;
      default: begin
        alu_res_s = '0;
        alu_ovf_s = 1'b0;
      end
    endcase
  end

`ifdef MULTICYCLE_ALU_MULDIV_EN
  // opa_r holds multiplier / dividend-then-quotient, opb_r multiplicand / divisor, acc_r product / remainder
  logic [3:0]       op_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] opa_nxt_s;
  logic [WIDTH-1:0] opb_nxt_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;

  assign multi_s = (bus.ALUControl == OP_MUL) || (bus.ALUControl == OP_DIVU) ||
                   (bus.ALUControl == OP_REMU);
  assign last_s  = (cnt_r == SHW'(WIDTH - 1));

  // One shift-add or restoring-division step per EXEC cycle
  always_comb begin
    shifted_s = {acc_r, opa_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, opb_r};
    if (op_r == OP_MUL) begin
      acc_nxt_s = opa_r[0] ? (acc_r + opb_r) : acc_r;
      opa_nxt_s = opa_r >> 1;
      opb_nxt_s = opb_r << 1;
    end else begin
      opb_nxt_s = opb_r;
      if (!trial_s[WIDTH]) begin
        acc_nxt_s = trial_s[WIDTH-1:0];
        opa_nxt_s = {opa_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = shifted_s[WIDTH-1:0];
        opa_nxt_s = {opa_r[WIDTH-2:0], 1'b0};
      end
    end
    case (op_r)
      OP_DIVU: fin_s = opa_nxt_s;
      default: fin_s = acc_nxt_s;
    endcase
  end

  // Iteration state: loaded on accepted start, stepped in EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r  <= 4'b0000;
      acc_r <= '0;
      opa_r <= '0;
      opb_r <= '0;
      cnt_r <= '0;
    end else if ((state_r == IDLE) && bus.start) begin
      op_r  <= bus.ALUControl;
      acc_r <= '0;
      opa_r <= bus.A;
      opb_r <= bus.B;
      cnt_r <= '0;
    end else if (state_r == EXEC) begin
      acc_r <= acc_nxt_s;
      opa_r <= opa_nxt_s;
      opb_r <= opb_nxt_s;
      cnt_r <= cnt_r + SHW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign multi_s = 1'b0;
  assign last_s  = 1'b0;
  assign fin_s   = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = multi_s ? EXEC : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Status decode from the state register
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      EXEC: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Result registers change only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= '0;
      zero_r   <= 1'b1;
      ovf_r    <= 1'b0;
    end else if ((state_r == IDLE) && bus.start && !multi_s) begin
      result_r <= alu_res_s;
      zero_r   <= (alu_res_s == '0);
      ovf_r    <= alu_ovf_s;
    end else if ((state_r == EXEC) && last_s) begin
      result_r <= fin_s;
      zero_r   <= (fin_s == '0);
      ovf_r    <= 1'b0;
    end else begin
      result_r <= result_r;
    end
  end

  assign bus.Result   = result_r;
  assign bus.Zero     = zero_r;
  assign bus.Overflow = ovf_r;
  assign bus.busy     = busy_s;
  assign bus.done     = done_s;
endmodule
